// File: rtl/dense_stage_fp_if.sv
// Handshake and weight-ROM bundle for the serial dense stage.
// master = word source / weight ROM side, slave = the accumulator stage.
interface dense_stage_fp_if #(
  parameter int NUM_IN      = 16,
  parameter int OUTPUT_SIZE = 128,
  parameter int BW          = 16,
  parameter int BW_W        = 2
);
  localparam int AW = $clog2(NUM_IN);

  logic                        vld_in;
  logic [BW-1:0]               data_in;
  logic                        clr;
  logic [AW-1:0]               w_addr;
  logic [OUTPUT_SIZE*BW_W-1:0] w_vec;
  logic                        vld_out;
  logic [OUTPUT_SIZE*BW-1:0]   data_out;
  logic                        busy;
  logic                        sat_flag;

  modport master (
    output vld_in, data_in, clr, w_vec,
    input  w_addr, vld_out, data_out, busy, sat_flag
  );

  modport slave (
    input  vld_in, data_in, clr, w_vec,
    output w_addr, vld_out, data_out, busy, sat_flag
  );
endinterface

// File: rtl/dense_stage_fp.sv
// Serial dense layer: one input word per accept, OUTPUT_SIZE parallel MACs, result 1 cycle after last word.
// No backpressure: every vld_in & !clr cycle is consumed; vld_in=0 stalls, clr aborts the frame.
module dense_stage_fp #(
  parameter int NUM_IN      = 16,
  parameter int OUTPUT_SIZE = 128,
  parameter int BW          = 16,
  parameter int BW_W        = 2,
  parameter int ACC_BW      = 32,
  parameter int R_SHIFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  dense_stage_fp_if.slave   bus
);
  localparam int AW = $clog2(NUM_IN);
  localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [AW-1:0]            w_addr_q;
  logic                     accept;
  logic                     last;

  logic signed [ACC_BW-1:0] acc     [OUTPUT_SIZE];
  logic signed [ACC_BW-1:0] wx      [OUTPUT_SIZE];
  logic signed [ACC_BW-1:0] sum     [OUTPUT_SIZE];
  logic signed [ACC_BW-1:0] shifted [OUTPUT_SIZE];
  logic [BW-1:0]            res     [OUTPUT_SIZE];
  logic signed [ACC_BW-1:0] din_x;
  logic                     clamp_any;

  logic [OUTPUT_SIZE*BW-1:0] data_q;
  logic                      vld_q;
  logic                      sat_q;

  assign accept = bus.vld_in & ~bus.clr;
  assign last   = (w_addr_q == AW'(NUM_IN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word 0 can never be the last word (NUM_IN >= 2), so a single accept from IDLE always enters ACC.
  always_comb begin
    state_nxt = state;
    if (bus.clr)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = last ? IDLE : ACC;
  end

  // Full-precision MAC per channel, then shift and clamp for the frame-closing word.
  always_comb begin
    din_x     = {{(ACC_BW-BW){bus.data_in[BW-1]}}, bus.data_in};
    clamp_any = 1'b0;
    for (int o = 0; o < OUTPUT_SIZE; o++) begin
      wx[o]      = {{(ACC_BW-BW_W){bus.w_vec[o*BW_W+BW_W-1]}}, bus.w_vec[o*BW_W +: BW_W]};
      sum[o]     = acc[o] + din_x * wx[o];
      shifted[o] = sum[o] >>> R_SHIFT;
      res[o]     = shifted[o][BW-1:0];
      if (shifted[o] > SAT_MAX) begin
        res[o]    = SAT_MAX[BW-1:0];
        clamp_any = 1'b1;
      end else if (shifted[o] < SAT_MIN) begin
        res[o]    = SAT_MIN[BW-1:0];
        clamp_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q <= '0;
      for (int o = 0; o < OUTPUT_SIZE; o++) acc[o] <= '0;
    end else if (bus.clr) begin
      w_addr_q <= '0;
      for (int o = 0; o < OUTPUT_SIZE; o++) acc[o] <= '0;
    end else if (accept) begin
      w_addr_q <= last ? '0 : w_addr_q + AW'(1);
      for (int o = 0; o < OUTPUT_SIZE; o++) acc[o] <= last ? '0 : sum[o];
    end
  end

  // vld_q is loaded unconditionally each edge, so a pulse registered before a clr still fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld_q <= accept & last;
      if (accept & last) begin
        for (int o = 0; o < OUTPUT_SIZE; o++) data_q[o*BW +: BW] <= res[o];
        if (clamp_any) sat_q <= 1'b1;
      end
    end
  end

  assign bus.w_addr   = w_addr_q;
  assign bus.vld_out  = vld_q;
  assign bus.data_out = data_q;
  assign bus.busy     = (state == ACC);
  assign bus.sat_flag = sat_q;
endmodule

// File: doc/dense_stage_fp.md
DENSE_STAGE_FP -- requirements
Module: dense_stage_fp

Interface
REQ-001 Parameter NUM_IN, 16: serial input words per frame (>=2).
REQ-002 Parameter OUTPUT_SIZE, 128: output channels.
REQ-003 Parameter BW, 16: signed data width, input and output.
REQ-004 Parameter BW_W, 2: signed two's-complement weight width.
REQ-005 Parameter ACC_BW, 32: signed accumulator width (>= BW+BW_W+clog2(NUM_IN)).
REQ-006 Parameter R_SHIFT, 0: arithmetic right shift applied before output saturation.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 vld_in  input  1  data_in carries a valid word this cycle.
REQ-010 data_in  input  BW  signed input word.
REQ-011 clr  input  1  synchronous abort; discards the partial frame.
REQ-012 w_addr  output  clog2(NUM_IN)  index of the word expected next; drives external weight ROM combinationally.
REQ-013 w_vec  input  OUTPUT_SIZE*BW_W  weights for w_addr, same cycle; channel o in bits [o*BW_W +: BW_W].
REQ-014 vld_out  output  1  one-cycle pulse; data_out holds a new frame result.
REQ-015 data_out  output  OUTPUT_SIZE*BW  signed saturated results; channel o in [o*BW +: BW].
REQ-016 busy  output  1  high while a partial frame is held (state ACC).
REQ-017 sat_flag  output  1  sticky; set when any output saturates.

Function
REQ-018 Two states: IDLE (w_addr=0, accumulators zero) and ACC (1..NUM_IN-1 words accepted).
REQ-019 IDLE -> ACC on vld_in & !clr; ACC -> IDLE on accepting word NUM_IN-1 or on clr; otherwise hold.
REQ-020 Word k is accepted when vld_in=1 & clr=0; w_addr then increments, wrapping NUM_IN-1 -> 0.
REQ-021 Per accepted word: acc[o] <= acc[o] + sext(data_in)*sext(w_vec[o]), full-precision signed product, ACC_BW wrap.
REQ-022 On accepting word NUM_IN-1: data_out[o] <= sat_BW((acc[o]+product) >>> R_SHIFT); acc[o] <= 0; vld_out=1 next cycle.
REQ-023 Latency: vld_out exactly 1 cycle after the last word's accept edge; no other cycle asserts vld_out.
REQ-024 Saturation clamps to [-2^(BW-1), 2^(BW-1)-1]; any clamp sets sat_flag, which clears only on rst.
REQ-025 data_out holds its value between vld_out pulses; it is not cleared by clr.
REQ-026 Full rate: word 0 of the next frame is accepted in the cycle after word NUM_IN-1, no bubble.
REQ-027 vld_in=0 cycles inside a frame stall the counter and accumulators without loss.
REQ-028 clr=1 (with or without vld_in): word discarded, acc zeroed, w_addr=0, state IDLE; a pending vld_out from the previous cycle still fires.
REQ-029 busy = (state==ACC), registered-state decode, no combinational path from vld_in.

Reset
REQ-030 rst asserts asynchronously: state IDLE, w_addr=0, acc=0, vld_out=0, data_out=0, busy=0, sat_flag=0.
REQ-031 Reset mid-frame discards the partial frame; first accepted word after deassertion is word 0.
REQ-032 Deassertion is synchronised externally; the block requires one clean edge before vld_in.

Verification
REQ-033 NUM_IN=4, OUTPUT_SIZE=2, R_SHIFT=0; data 1,2,3,4; ch0 w=+1, ch1 w=-1 -> one cycle later vld_out=1, ch0=10, ch1=-10, sat_flag=0.
REQ-034 Same config, data 32767 x4, ch0 w=+1, ch1 w=-2 -> ch0=32767, ch1=-32768, sat_flag=1 and stays 1 across next frame.
REQ-035 Two frames back-to-back with vld_in held high 8 cycles (1..4 then 5..8, w=+1) -> vld_out pulses at cycles 5 and 9, ch0=10 then 26.
REQ-036 Frame 1,2, idle 3 cycles, then 3,4 -> ch0=10; busy high from first accept to last accept; w_addr stalls at 2.
REQ-037 Words 1,2 then clr=1 with vld_in=1 (data 9), then 1,1,1,1 -> no vld_out until ch0=4; 9 is not counted.
REQ-038 rst pulsed asynchronously after 2 words -> all outputs 0 immediately; following 4,4,4,4 with R_SHIFT=2 gives ch0=4.
